// File: rtl/flits_buffer_vc_if.sv
// Handshake/bus bundle for flits_buffer_vc.
//   slave  : the buffer itself (consumes flits and grant, drives credits/packet).
//   master : the environment (router link + message stage).
// Signals:
//   in_link_i, is_valid_i, vc_id_i  incoming flit and its target VC
//   credit_o, free_o                per-VC slot release pulse / slot-empty level
//   r_pkt_to_msg_o, g_pkt_to_msg_i  packet request / grant
//   out_link_o, out_vc_o, out_len_o presented packet, its VC and flit count
//   err_o                           protocol error pulse
interface flits_buffer_vc_if #(
  parameter int FLIT_WIDTH  = 64,
  parameter int MAX_PKT_LEN = 8,
  parameter int N_VC        = 2,
  parameter int N_BITS_VC   = (N_VC > 1) ? $clog2(N_VC) : 1,
  parameter int N_BITS_LEN  = $clog2(MAX_PKT_LEN + 1)
);
  logic [FLIT_WIDTH-1:0]             in_link_i;
  logic                              is_valid_i;
  logic [N_BITS_VC-1:0]              vc_id_i;
  logic [N_VC-1:0]                   credit_o;
  logic [N_VC-1:0]                   free_o;
  logic                              r_pkt_to_msg_o;
  logic                              g_pkt_to_msg_i;
  logic [MAX_PKT_LEN*FLIT_WIDTH-1:0] out_link_o;
  logic [N_BITS_VC-1:0]              out_vc_o;
  logic [N_BITS_LEN-1:0]             out_len_o;
  logic                              err_o;

  modport slave (
    input  in_link_i, is_valid_i, vc_id_i, g_pkt_to_msg_i,
    output credit_o, free_o, r_pkt_to_msg_o, out_link_o, out_vc_o, out_len_o, err_o
  );

  modport master (
    output in_link_i, is_valid_i, vc_id_i, g_pkt_to_msg_i,
    input  credit_o, free_o, r_pkt_to_msg_o, out_link_o, out_vc_o, out_len_o, err_o
  );
endinterface

// File: rtl/flits_buffer_vc.sv
// Multi-VC flits buffer: collects flits into one packet slot per VC, a
// round-robin arbiter presents complete packets in parallel form to the
// message stage, and freed slots are returned upstream as credits.
// Ports:
//   clk  clock
//   rst  asynchronous active-high reset
//   bus  flits_buffer_vc_if.slave (flit input, packet output, credits, error)
//
// Per-VC state table:
//   state     | meaning
//   S_EMPTY   | slot empty, waiting for a head / head-tail flit
//   S_FILLING | head accepted, collecting body flits until the tail
//   S_FULL    | packet complete, waiting to be granted
module flits_buffer_vc #(
  parameter int FLIT_WIDTH  = 64,
  parameter int MAX_PKT_LEN = 8,
  parameter int N_VC        = 2,
  parameter int N_BITS_VC   = (N_VC > 1) ? $clog2(N_VC) : 1,
  parameter int N_BITS_LEN  = $clog2(MAX_PKT_LEN + 1)
) (
  input  logic              clk,
  input  logic              rst,
  flits_buffer_vc_if.slave  bus
);
  localparam int PKT_W = MAX_PKT_LEN * FLIT_WIDTH;

  typedef enum logic [1:0] {S_EMPTY, S_FILLING, S_FULL} vc_state_t;

  vc_state_t             state_q [N_VC];
  vc_state_t             state_d [N_VC];
  logic [FLIT_WIDTH-1:0] slot_q  [N_VC][MAX_PKT_LEN];
  logic [N_BITS_LEN-1:0] cnt_q   [N_VC];
  logic [N_BITS_LEN-1:0] cnt_d   [N_VC];
  logic [N_BITS_LEN-1:0] wr_idx  [N_VC];
  logic [N_VC-1:0]       wr_en;
  logic [N_VC-1:0]       clr;
  logic                  err_d, err_q;

  logic [1:0]            ftype;
  logic                  is_head, is_tail;

  logic                  req_q;
  logic [N_BITS_VC-1:0]  sel_q, rr_q, pick;
  logic                  found;
  logic [PKT_W-1:0]      pick_link, out_link_q;
  logic [N_BITS_LEN-1:0] pick_len, out_len_q;
  logic [N_BITS_VC-1:0]  out_vc_q;
  logic [N_VC-1:0]       credit_q;
  logic [N_VC-1:0]       free_w;
  logic                  grant;

  assign ftype   = bus.in_link_i[1:0];
  assign is_head = (ftype == 2'b00) || (ftype == 2'b11);
  assign is_tail = ftype[1];
  assign grant   = req_q & bus.g_pkt_to_msg_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int v = 0; v < N_VC; v++) state_q[v] <= S_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    err_d  = bus.is_valid_i && (int'(bus.vc_id_i) >= N_VC);
    wr_en  = '0;
    clr    = '0;
    for (int v = 0; v < N_VC; v++) begin
      state_d[v] = state_q[v];
      cnt_d[v]   = cnt_q[v];
      wr_idx[v]  = cnt_q[v];
      if (grant && int'(sel_q) == v) begin
        state_d[v] = S_EMPTY;
        cnt_d[v]   = '0;
        clr[v]     = 1'b1;
      end
      if (bus.is_valid_i && int'(bus.vc_id_i) == v) begin
        unique case (state_q[v])
          S_EMPTY: begin
            if (is_head) begin
              wr_en[v]   = 1'b1;
              wr_idx[v]  = '0;
              cnt_d[v]   = N_BITS_LEN'(1);
              state_d[v] = is_tail ? S_FULL : S_FILLING;
            end else begin
              err_d = 1'b1;
            end
          end
          S_FILLING: begin
            if (is_head) begin
              // a new head abandons the partial packet and restarts at slot 0
              err_d      = 1'b1;
              clr[v]     = 1'b1;
              wr_en[v]   = 1'b1;
              wr_idx[v]  = '0;
              cnt_d[v]   = N_BITS_LEN'(1);
              state_d[v] = is_tail ? S_FULL : S_FILLING;
            end else if (cnt_q[v] == N_BITS_LEN'(MAX_PKT_LEN)) begin
              // slot exhausted: drop the flit, but a tail still closes the packet
              err_d = 1'b1;
              if (is_tail) state_d[v] = S_FULL;
            end else begin
              wr_en[v] = 1'b1;
              cnt_d[v] = cnt_q[v] + 1'b1;
              if (is_tail) state_d[v] = S_FULL;
            end
          end
          S_FULL:  err_d = 1'b1;
          default: err_d = 1'b1;
        endcase
      end
    end
  end

  // first FULL VC at or after rr_q, wrapping
  always_comb begin
    found     = 1'b0;
    pick      = '0;
    pick_len  = '0;
    pick_link = '0;
    for (int i = 0; i < N_VC; i++) begin
      for (int v = 0; v < N_VC; v++) begin
        if (!found && state_q[v] == S_FULL && v == (int'(rr_q) + i) % N_VC) begin
          found    = 1'b1;
          pick     = N_BITS_VC'(v);
          pick_len = cnt_q[v];
          for (int k = 0; k < MAX_PKT_LEN; k++)
            pick_link[k*FLIT_WIDTH +: FLIT_WIDTH] = slot_q[v][k];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int v = 0; v < N_VC; v++) begin
        cnt_q[v] <= '0;
        for (int k = 0; k < MAX_PKT_LEN; k++) slot_q[v][k] <= '0;
      end
      err_q      <= 1'b0;
      credit_q   <= '0;
      req_q      <= 1'b0;
      sel_q      <= '0;
      rr_q       <= '0;
      out_link_q <= '0;
      out_vc_q   <= '0;
      out_len_q  <= '0;
    end else begin
      err_q    <= err_d;
      credit_q <= '0;
      for (int v = 0; v < N_VC; v++) begin
        cnt_q[v] <= cnt_d[v];
        for (int k = 0; k < MAX_PKT_LEN; k++) begin
          if (clr[v]) slot_q[v][k] <= '0;
          if (wr_en[v] && int'(wr_idx[v]) == k) slot_q[v][k] <= bus.in_link_i;
        end
      end
      if (req_q) begin
        // selection stays locked until the grant
        if (bus.g_pkt_to_msg_i) begin
          req_q      <= 1'b0;
          credit_q   <= N_VC'(1) << sel_q;
          rr_q       <= (int'(sel_q) == N_VC - 1) ? '0 : sel_q + 1'b1;
          out_link_q <= '0;
          out_vc_q   <= '0;
          out_len_q  <= '0;
        end
      end else if (found) begin
        req_q      <= 1'b1;
        sel_q      <= pick;
        out_link_q <= pick_link;
        out_vc_q   <= pick;
        out_len_q  <= pick_len;
      end
    end
  end

  always_comb begin
    free_w = '0;
    for (int v = 0; v < N_VC; v++) free_w[v] = (state_q[v] == S_EMPTY);
  end

  assign bus.credit_o       = credit_q;
  assign bus.free_o         = free_w;
  assign bus.r_pkt_to_msg_o = req_q;
  assign bus.out_link_o     = out_link_q;
  assign bus.out_vc_o       = out_vc_q;
  assign bus.out_len_o      = out_len_q;
  assign bus.err_o          = err_q;
endmodule

// File: tb/tb_flits_buffer_vc.sv
module tb_flits_buffer_vc;
  localparam int FW  = 64;
  localparam int MPL = 8;
  localparam int NV  = 2;
  localparam int NBV = 1;
  localparam int PW  = FW * MPL;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  flits_buffer_vc_if #(.FLIT_WIDTH(FW), .MAX_PKT_LEN(MPL), .N_VC(NV)) bus ();
  flits_buffer_vc #(.FLIT_WIDTH(FW), .MAX_PKT_LEN(MPL), .N_VC(NV)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model: packets as flit queues ----------------
  logic [FW-1:0] m_q [NV][$];
  bit            m_open [NV];
  bit            m_done [NV];
  bit            m_req;
  int            m_sel, m_rr, m_len, m_vc;
  logic [PW-1:0] m_link;
  logic [NV-1:0] m_credit;
  bit            m_err;

  task automatic model_reset();
    for (int v = 0; v < NV; v++) begin
      m_q[v].delete();
      m_open[v] = 0;
      m_done[v] = 0;
    end
    m_req = 0; m_sel = 0; m_rr = 0; m_len = 0; m_vc = 0;
    m_link = '0; m_credit = '0; m_err = 0;
  endtask

  task automatic model_step();
    logic [FW-1:0] f;
    int vc, gvc, v;
    logic [1:0] t;
    bit head, tail;
    gvc = -1;
    m_err = 0;
    m_credit = '0;
    if (m_req) begin
      if (bus.g_pkt_to_msg_i) begin
        gvc = m_sel;
        m_credit = NV'(1) << m_sel;
        m_req = 0; m_link = '0; m_len = 0; m_vc = 0;
        m_rr = (m_sel + 1) % NV;
      end
    end else begin
      for (int i = 0; i < NV; i++) begin
        v = (m_rr + i) % NV;
        if (!m_req && m_done[v]) begin
          m_req = 1; m_sel = v; m_vc = v; m_len = m_q[v].size(); m_link = '0;
          for (int k = 0; k < m_q[v].size(); k++) m_link[k*FW +: FW] = m_q[v][k];
        end
      end
    end
    if (bus.is_valid_i) begin
      f = bus.in_link_i;
      vc = int'(bus.vc_id_i);
      t = f[1:0];
      head = (t == 2'b00) || (t == 2'b11);
      tail = t[1];
      if (vc >= NV || m_done[vc]) m_err = 1;
      else if (!m_open[vc]) begin
        if (head) begin
          m_q[vc].delete(); m_q[vc].push_back(f);
          if (tail) m_done[vc] = 1; else m_open[vc] = 1;
        end else m_err = 1;
      end else if (head) begin
        m_err = 1;
        m_q[vc].delete(); m_q[vc].push_back(f);
        if (tail) begin m_open[vc] = 0; m_done[vc] = 1; end
      end else if (m_q[vc].size() == MPL) begin
        m_err = 1;
        if (tail) begin m_open[vc] = 0; m_done[vc] = 1; end
      end else begin
        m_q[vc].push_back(f);
        if (tail) begin m_open[vc] = 0; m_done[vc] = 1; end
      end
    end
    if (gvc >= 0) begin
      m_q[gvc].delete();
      m_done[gvc] = 0;
    end
  endtask

  function automatic logic [NV-1:0] model_free();
    logic [NV-1:0] r;
    r = '0;
    for (int v = 0; v < NV; v++) r[v] = !m_open[v] && !m_done[v];
    return r;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) model_reset();
    else model_step();
    #1;
    chk("cyc_req",    bus.r_pkt_to_msg_o, m_req);
    chk("cyc_link",   bus.out_link_o,     m_link);
    chk("cyc_vc",     bus.out_vc_o,       m_vc);
    chk("cyc_len",    bus.out_len_o,      m_len);
    chk("cyc_credit", bus.credit_o,       m_credit);
    chk("cyc_free",   bus.free_o,         model_free());
    chk("cyc_err",    bus.err_o,          m_err);
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc();
    @(negedge clk);
    bus.is_valid_i = 1'b0; bus.g_pkt_to_msg_i = 1'b0;
    bus.in_link_i = '0; bus.vc_id_i = '0;
  endtask

  task automatic send(input int vc, input logic [FW-1:0] f);
    @(negedge clk);
    bus.is_valid_i = 1'b1; bus.vc_id_i = NBV'(vc);
    bus.in_link_i = f; bus.g_pkt_to_msg_i = 1'b0;
  endtask

  task automatic grant();
    @(negedge clk);
    bus.is_valid_i = 1'b0; bus.g_pkt_to_msg_i = 1'b1;
  endtask

  task automatic wait_req(input string name);
    int n;
    n = 0;
    while (bus.r_pkt_to_msg_o !== 1'b1 && n < 20) begin
      cyc();
      n++;
    end
    chk({name, "_req"}, bus.r_pkt_to_msg_o, 1'b1);
  endtask

  task automatic test1();
    send(0, 64'hFF3);
    cyc();
    chk("t1_req_early", bus.r_pkt_to_msg_o, 1'b0);
    cyc();
    chk("t1_req", bus.r_pkt_to_msg_o, 1'b1);
    chk("t1_flit0", bus.out_link_o[63:0], 64'hFF3);
    chk("t1_len", bus.out_len_o, 1);
    chk("t1_vc", bus.out_vc_o, 0);
    chk("t1_model_len", m_len, 1);
    grant();
    cyc();
    chk("t1_credit", bus.credit_o, 2'b01);
    chk("t1_free", bus.free_o, 2'b11);
    chk("t1_req_drop", bus.r_pkt_to_msg_o, 1'b0);
    cyc();
    chk("t1_credit_end", bus.credit_o, 2'b00);
  endtask

  logic [FW-1:0] data;
  int rnd;

  initial begin
    rst = 1'b1;
    bus.is_valid_i = 1'b0; bus.g_pkt_to_msg_i = 1'b0;
    bus.in_link_i = '0; bus.vc_id_i = '0;
    repeat (3) @(negedge clk);
    chk("rst_free", bus.free_o, 2'b11);
    chk("rst_req", bus.r_pkt_to_msg_o, 1'b0);
    rst = 1'b0;
    cyc();

    test1();

    // test 2: VC1 five-flit packet with a bubble
    send(1, 64'h00); send(1, 64'h11); send(1, 64'h21); cyc();
    send(1, 64'h31); send(1, 64'h72);
    wait_req("t2");
    chk("t2_len", bus.out_len_o, 5);
    chk("t2_vc", bus.out_vc_o, 1);
    chk("t2_flit4", bus.out_link_o[4*FW +: FW], 64'h72);
    grant(); cyc();

    // test 3: both VCs complete, round-robin order over two rounds
    for (int r = 0; r < 2; r++) begin
      send(0, 64'h103 + 64'(r * 8)); send(1, 64'h207 + 64'(r * 8));
      wait_req("t3a");
      chk("t3_first_vc", bus.out_vc_o, 0);
      grant(); cyc();
      wait_req("t3b");
      chk("t3_second_vc", bus.out_vc_o, 1);
      grant(); cyc();
    end

    // test 4: overflow then tail at full count
    send(0, 64'h00);
    for (int i = 0; i < 8; i++) send(0, 64'h01);
    cyc();
    chk("t4_overflow_err", bus.err_o, 1'b1);
    send(0, 64'h02);
    cyc();
    chk("t4_tail_err", bus.err_o, 1'b1);
    wait_req("t4");
    chk("t4_len", bus.out_len_o, 8);
    chk("t4_vc", bus.out_vc_o, 0);
    grant(); cyc();

    // test 5: body into empty VC, double head restart
    send(1, 64'h01);
    cyc();
    chk("t5_body_err", bus.err_o, 1'b1);
    chk("t5_free1", bus.free_o[1], 1'b1);
    cyc();
    chk("t5_no_req", bus.r_pkt_to_msg_o, 1'b0);
    send(1, 64'h00); send(1, 64'h00);
    cyc();
    chk("t5_head_err", bus.err_o, 1'b1);
    send(1, 64'h02);
    wait_req("t5");
    chk("t5_len", bus.out_len_o, 2);
    chk("t5_flit1", bus.out_link_o[FW +: FW], 64'h02);
    grant(); cyc();

    // test 6: reset mid-traffic
    send(1, 64'hA3);
    wait_req("t6");
    send(0, 64'h00);
    cyc();
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("t6_req", bus.r_pkt_to_msg_o, 1'b0);
    chk("t6_free", bus.free_o, 2'b11);
    chk("t6_link", bus.out_link_o, '0);
    chk("t6_len", bus.out_len_o, 0);
    chk("t6_credit", bus.credit_o, 2'b00);
    cyc(); cyc();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("t6_no_credit", bus.credit_o, 2'b00);
    end
    test1();

    // randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      rnd = $urandom_range(0, 19);
      data = {$urandom, $urandom};
      data[1:0] = (rnd < 5) ? 2'b00 : (rnd < 13) ? 2'b01 : (rnd < 18) ? 2'b10 : 2'b11;
      bus.in_link_i = data;
      bus.is_valid_i = ($urandom_range(0, 9) < 6);
      bus.vc_id_i = NBV'($urandom_range(0, NV - 1));
      bus.g_pkt_to_msg_i = ($urandom_range(0, 9) < 3);
    end
    repeat (3) cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
